tm_class_argmax: RTL and testbench
==================================

TM_CLASS_ARGMAX -- requirements
Module: tm_class_argmax

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NUM_CLASSES, 10, number of class sums compared.
- SUM_W, 32, width of each signed class sum.
- CNT_W, 16, width of the statistics counters.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on the rising edge.
- rst_flag, in, 1, synchronous active-high reset.
- class_sum_1 .. class_sum_10, in, SUM_W each, signed class sums from the classifier.
- full_done, in, 1, classifier completion level.
- label, in, 4, ground-truth class index (0..9), sampled together with the sums.
- pred_ready, in, 1, consumer accepts the prediction.
- pred_valid, out, 1, prediction available.
- pred_class, out, 4, winning class index (0 = class_sum_1).
- pred_max, out, SUM_W, signed winning sum.
- pred_correct, out, 1, pred_class == captured label.
- busy, out, 1, state is not IDLE.
- sample_count, out, CNT_W, accepted predictions.
- correct_count, out, CNT_W, accepted predictions where pred_correct=1.
- missed_flag, out, 1, sticky: a full_done rising edge arrived while busy.

Function
REQ-003 The block SHALL register full_done each cycle into done_d and detect a start as full_done=1 and done_d=0.
REQ-004 The FSM SHALL have exactly three states: IDLE, SCAN and HOLD.
REQ-005 In IDLE on a start, the block SHALL:
- snapshot all 10 sums and label into internal registers;
- set best=snapshot[0], best_idx=0, idx=1;
- enter SCAN.
REQ-006 In SCAN, each cycle the block SHALL perform one signed compare of snapshot[idx] against best and replace best/best_idx only if strictly greater; ties therefore resolve to the lowest index.
REQ-007 In SCAN, idx SHALL increment each cycle; the compare at idx=9 SHALL transition to HOLD.
REQ-008 Latency: pred_valid SHALL rise exactly 9 cycles after the capturing edge, since SCAN performs 9 compares.
REQ-009 In HOLD, pred_valid SHALL be 1, and pred_class, pred_max and pred_correct SHALL be stable until the handshake.
REQ-010 Handshake: pred_valid=1 and pred_ready=1 at a rising edge SHALL:
- return the FSM to IDLE;
- increment sample_count;
- increment correct_count if pred_correct=1.
pred_valid SHALL be 0 in the following cycle.
REQ-011 pred_ready while not in HOLD SHALL have no effect.
REQ-012 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-013 A start detected in SCAN or HOLD SHALL NOT disturb the snapshot or outputs, and SHALL set missed_flag.
REQ-014 A start in the same cycle as a HOLD handshake SHALL be counted as missed and not captured; done_d still updates, so the held-high full_done does not retrigger.
REQ-015 All 10 inputs sampled at the capture edge SHALL be used; later input changes SHALL be ignored.
REQ-016 Comparisons SHALL be signed two's complement; the most negative value (0x80000000) SHALL compare correctly.

Reset
REQ-017 rst_flag=1 at a rising edge SHALL set:
- state to IDLE;
- pred_valid, pred_correct, busy and missed_flag to 0;
- pred_class and pred_max to 0;
- both counters and done_d to 0.
This applies in any state, including mid-SCAN, and SHALL discard the scan in progress.
REQ-018 If full_done is already high in the first cycle after reset, it SHALL count as a start, because done_d=0.

Verification
REQ-019 Distinct maximum: sums = 1..10 with class_sum_7=500, label=6, full_done 0->1 -> pred_valid rises 9 cycles later with pred_class=6, pred_max=500, pred_correct=1; with pred_ready=1 -> sample_count=1, correct_count=1.
REQ-020 Ties and negatives: all sums = -5 except class_sum_3 = class_sum_8 = -2 -> pred_class=2, pred_max=-2 (0xFFFFFFFE); all sums = 0x80000000 -> pred_class=0.
REQ-021 Backpressure and miss: hold pred_ready=0 for 20 cycles while sums change and full_done pulses again -> outputs unchanged, missed_flag=1; then pred_ready=1 -> one increment only.
REQ-022 Reset mid-scan: assert rst_flag 4 cycles after start -> next cycle pred_valid=0, busy=0, counters=0; a new start then completes normally in 9 cycles.
REQ-023 Saturation: 65,537 wrong-label transactions -> sample_count=0xFFFF, correct_count=0, no wrap.

Source files
------------

// File: rtl/tm_class_argmax.sv
// Tsetlin-machine class argmax: snapshots the class sums when the classifier finishes.
// It then scans them one compare per cycle and holds the winning index and sum until the
// consumer accepts it. Accepted predictions are counted, and so are the correct ones.
// The ten sum ports are fixed, so NUM_CLASSES must stay at 10.
module tm_class_argmax #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned SUM_W       = 32,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_flag,
  input  logic [SUM_W-1:0] class_sum_1,
  input  logic [SUM_W-1:0] class_sum_2,
  input  logic [SUM_W-1:0] class_sum_3,
  input  logic [SUM_W-1:0] class_sum_4,
  input  logic [SUM_W-1:0] class_sum_5,
  input  logic [SUM_W-1:0] class_sum_6,
  input  logic [SUM_W-1:0] class_sum_7,
  input  logic [SUM_W-1:0] class_sum_8,
  input  logic [SUM_W-1:0] class_sum_9,
  input  logic [SUM_W-1:0] class_sum_10,
  input  logic             full_done,
  input  logic [3:0]       label,
  input  logic             pred_ready,
  output logic             pred_valid,
  output logic [3:0]       pred_class,
  output logic [SUM_W-1:0] pred_max,
  output logic             pred_correct,
  output logic             busy,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] correct_count,
  output logic             missed_flag
);

  localparam logic [3:0] LastIdx = 4'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {StIdle, StScan, StHold} state_e;

  state_e state_q, state_d;

  logic signed [SUM_W-1:0] sums_in [NUM_CLASSES];
  logic signed [SUM_W-1:0] snap_q  [NUM_CLASSES];
  logic        [3:0]       label_q;
  logic signed [SUM_W-1:0] best_q;
  logic        [3:0]       best_idx_q;
  logic        [3:0]       idx_q;
  logic                    done_dly_q;
  logic                    missed_q;
  logic        [3:0]       pred_class_q;
  logic        [SUM_W-1:0] pred_max_q;
  logic                    pred_correct_q;
  logic        [CNT_W-1:0] sample_cnt_q;
  logic        [CNT_W-1:0] correct_cnt_q;

  logic                    start;
  logic                    handshake;
  logic                    scan_last;
  logic signed [SUM_W-1:0] cand;
  logic                    cand_gt;
  logic signed [SUM_W-1:0] win_max;
  logic        [3:0]       win_idx;

  // Gather the flat sum ports into an indexable array (index 0 = class_sum_1).
  always_comb begin
    sums_in[0] = class_sum_1;
    sums_in[1] = class_sum_2;
    sums_in[2] = class_sum_3;
    sums_in[3] = class_sum_4;
    sums_in[4] = class_sum_5;
    sums_in[5] = class_sum_6;
    sums_in[6] = class_sum_7;
    sums_in[7] = class_sum_8;
    sums_in[8] = class_sum_9;
    sums_in[9] = class_sum_10;
  end

  // Start strobe, handshake and the single signed compare of the scan.
  always_comb begin
    start     = full_done & ~done_dly_q;
    handshake = (state_q == StHold) & pred_ready;
    scan_last = (state_q == StScan) & (idx_q == LastIdx);
    cand      = snap_q[idx_q];
    // Strictly greater keeps the lower index on ties.
    cand_gt   = cand > best_q;
    win_max   = cand_gt ? cand : best_q;
    win_idx   = cand_gt ? idx_q : best_idx_q;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst_flag) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start)      state_d = StScan;
      StScan: if (scan_last)  state_d = StHold;
      StHold: if (pred_ready) state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  // FSM-decoded outputs.
  always_comb begin
    pred_valid = (state_q == StHold);
    busy       = (state_q != StIdle);
  end

  // Completion edge detect and sticky flag for starts that arrive while busy.
  always_ff @(posedge clk) begin
    if (rst_flag) begin
      done_dly_q <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      done_dly_q <= full_done;
      if (start && (state_q != StIdle)) begin
        missed_q <= 1'b1;
      end
    end
  end

  // Snapshot capture; only loaded from IDLE, so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst_flag && (state_q == StIdle) && start) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        snap_q[i] <= sums_in[i];
      end
      label_q <= label;
    end
  end

  // Running maximum and scan index.
  always_ff @(posedge clk) begin
    if (rst_flag) begin
      best_q     <= '0;
      best_idx_q <= '0;
      idx_q      <= '0;
    end else if ((state_q == StIdle) && start) begin
      best_q     <= sums_in[0];
      best_idx_q <= 4'd0;
      idx_q      <= 4'd1;
    end else if (state_q == StScan) begin
      best_q     <= win_max;
      best_idx_q <= win_idx;
      idx_q      <= idx_q + 4'd1;
    end
  end

  // Prediction registers, loaded by the final compare and held until the next scan ends.
  always_ff @(posedge clk) begin
    if (rst_flag) begin
      pred_class_q   <= '0;
      pred_max_q     <= '0;
      pred_correct_q <= 1'b0;
    end else if (scan_last) begin
      pred_class_q   <= win_idx;
      pred_max_q     <= win_max;
      pred_correct_q <= (win_idx == label_q);
    end
  end

  // Saturating statistics counters, advanced only on an accepted prediction.
  always_ff @(posedge clk) begin
    if (rst_flag) begin
      sample_cnt_q  <= '0;
      correct_cnt_q <= '0;
    end else if (handshake) begin
      if (sample_cnt_q != '1) begin
        sample_cnt_q <= sample_cnt_q + 1'b1;
      end
      if (pred_correct_q && (correct_cnt_q != '1)) begin
        correct_cnt_q <= correct_cnt_q + 1'b1;
      end
    end
  end

  assign pred_class    = pred_class_q;
  assign pred_max      = pred_max_q;
  assign pred_correct  = pred_correct_q;
  assign sample_count  = sample_cnt_q;
  assign correct_count = correct_cnt_q;
  assign missed_flag   = missed_q;

endmodule

// File: tb/tb_tm_class_argmax.sv
// Scoreboard bench for tm_class_argmax: the driver pushes hand-computed predictions and a
// monitor pops and compares them when pred_valid rises. Counters use an 8-bit width so
// saturation is reachable in a short run.
module tb_tm_class_argmax;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_flag;
  logic [31:0]   sum_drv [10];
  logic          full_done;
  logic [3:0]    label;
  logic          pred_ready;
  logic          pred_valid;
  logic [3:0]    pred_class;
  logic [31:0]   pred_max;
  logic          pred_correct;
  logic          busy;
  logic [CW-1:0] sample_count;
  logic [CW-1:0] correct_count;
  logic          missed_flag;

  typedef struct {
    logic [3:0]  cls;
    logic [31:0] mx;
    logic        corr;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cycle = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic valid_prev = 1'b0;

  tm_class_argmax #(
    .NUM_CLASSES(10),
    .SUM_W      (32),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .rst_flag     (rst_flag),
    .class_sum_1  (sum_drv[0]),
    .class_sum_2  (sum_drv[1]),
    .class_sum_3  (sum_drv[2]),
    .class_sum_4  (sum_drv[3]),
    .class_sum_5  (sum_drv[4]),
    .class_sum_6  (sum_drv[5]),
    .class_sum_7  (sum_drv[6]),
    .class_sum_8  (sum_drv[7]),
    .class_sum_9  (sum_drv[8]),
    .class_sum_10 (sum_drv[9]),
    .full_done    (full_done),
    .label        (label),
    .pred_ready   (pred_ready),
    .pred_valid   (pred_valid),
    .pred_class   (pred_class),
    .pred_max     (pred_max),
    .pred_correct (pred_correct),
    .busy         (busy),
    .sample_count (sample_count),
    .correct_count(correct_count),
    .missed_flag  (missed_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: each new prediction is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (pred_valid && !valid_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_class", 64'(pred_class), 64'(e.cls));
        check("sb_max", 64'(pred_max), 64'(e.mx));
        check("sb_correct", 64'(pred_correct), 64'(e.corr));
        check("sb_latency", 64'(cycle), 64'(e.cyc));
      end
    end
    valid_prev = pred_valid;
  end

  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < 10; i++) sum_drv[i] = v;
  endtask

  // Called just after a negedge; the next rising edge captures.
  task automatic issue(input logic [3:0] lbl, input logic [3:0] ecls, input logic [31:0] emax,
                       input logic ecorr);
    exp_t e;
    label     = lbl;
    full_done = 1'b1;
    e.cls  = ecls;
    e.mx   = emax;
    e.corr = ecorr;
    e.cyc  = cycle + 10;
    sb.push_back(e);
    @(negedge clk);
    full_done = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!pred_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!pred_valid) check("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic accept();
    pred_ready = 1'b1;
    @(negedge clk);
    pred_ready = 1'b0;
    check("valid_drop", 64'(pred_valid), 64'd0);
  endtask

  task automatic counts(input string name, input int s, input int c);
    check({name, "_samples"}, 64'(sample_count), 64'(s));
    check({name, "_correct"}, 64'(correct_count), 64'(c));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got hang, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_flag   = 1'b1;
    full_done  = 1'b0;
    label      = 4'd0;
    pred_ready = 1'b0;
    fill(32'd0);
    repeat (2) @(negedge clk);
    rst_flag = 1'b0;

    // Reset state
    check("rst_valid", 64'(pred_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_class", 64'(pred_class), 64'd0);
    check("rst_max", 64'(pred_max), 64'd0);
    check("rst_missed", 64'(missed_flag), 64'd0);
    counts("rst", 0, 0);

    // Distinct maximum at class_sum_7; inputs scrambled after capture must be ignored
    for (int i = 0; i < 10; i++) sum_drv[i] = 32'(i + 1);
    sum_drv[6] = 32'd500;
    issue(4'd6, 4'd6, 32'd500, 1'b1);
    fill(32'h7FFF_FFFF);
    label = 4'd0;
    check("busy_scan", 64'(busy), 64'd1);
    wait_valid();
    accept();
    counts("t1", 1, 1);

    // Ties among negatives resolve to the lowest index; ready held high through the scan
    fill(32'hFFFF_FFFB);
    sum_drv[2] = 32'hFFFF_FFFE;
    sum_drv[7] = 32'hFFFF_FFFE;
    pred_ready = 1'b1;
    issue(4'd3, 4'd2, 32'hFFFF_FFFE, 1'b0);
    wait_idle();
    pred_ready = 1'b0;
    counts("t2", 2, 1);

    // All most-negative: tie goes to class 0
    fill(32'h8000_0000);
    issue(4'd0, 4'd0, 32'h8000_0000, 1'b1);
    wait_valid();
    accept();
    counts("t3", 3, 2);

    // Winner in the last slot, most-negative in the first
    fill(32'hFFFF_FF9C);
    sum_drv[0] = 32'h8000_0000;
    sum_drv[9] = 32'hFFFF_FFFF;
    issue(4'd9, 4'd9, 32'hFFFF_FFFF, 1'b1);
    wait_valid();
    accept();
    counts("t4", 4, 3);
    check("no_miss_yet", 64'(missed_flag), 64'd0);

    // Backpressure: outputs hold while inputs churn and a second completion pulses
    fill(32'd0);
    sum_drv[4] = 32'd1000;
    issue(4'd2, 4'd4, 32'd1000, 1'b0);
    wait_valid();
    for (int c = 0; c < 20; c++) begin
      sum_drv[c % 10] = $urandom;
      label = 4'($urandom_range(0, 9));
      full_done = (c == 5);
      @(negedge clk);
      check("hold_valid", 64'(pred_valid), 64'd1);
      check("hold_class", 64'(pred_class), 64'd4);
      check("hold_max", 64'(pred_max), 64'd1000);
    end
    full_done = 1'b0;
    check("miss_set", 64'(missed_flag), 64'd1);
    accept();
    counts("t5", 5, 3);
    repeat (3) @(negedge clk);
    check("miss_not_captured", 64'(busy), 64'd0);

    // Reset four cycles into a scan discards it
    for (int i = 0; i < 10; i++) sum_drv[i] = 32'(i);
    issue(4'd9, 4'd9, 32'd9, 1'b1);
    repeat (3) @(negedge clk);
    rst_flag = 1'b1;
    @(negedge clk);
    rst_flag = 1'b0;
    sb.delete();
    check("midrst_valid", 64'(pred_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_missed", 64'(missed_flag), 64'd0);
    counts("midrst", 0, 0);
    sum_drv[3] = 32'd77;
    issue(4'd3, 4'd3, 32'd77, 1'b1);
    wait_valid();
    accept();
    counts("t7", 1, 1);

    // Start coinciding with the handshake is missed and the held level does not retrigger
    fill(32'd5);
    sum_drv[8] = 32'd6;
    issue(4'd1, 4'd8, 32'd6, 1'b0);
    wait_valid();
    pred_ready = 1'b1;
    full_done  = 1'b1;
    @(negedge clk);
    pred_ready = 1'b0;
    check("coinc_valid", 64'(pred_valid), 64'd0);
    check("coinc_missed", 64'(missed_flag), 64'd1);
    counts("t8", 2, 1);
    repeat (3) @(negedge clk);
    check("coinc_no_capture", 64'(busy), 64'd0);
    full_done = 1'b0;

    // full_done already high when reset releases counts as a start
    fill(32'd1);
    sum_drv[5] = 32'd2;
    label      = 4'd5;
    rst_flag   = 1'b1;
    full_done  = 1'b1;
    @(negedge clk);
    rst_flag = 1'b0;
    sb.delete();
    begin
      exp_t e;
      e.cls = 4'd5; e.mx = 32'd2; e.corr = 1'b1; e.cyc = cycle + 10;
      sb.push_back(e);
    end
    @(negedge clk);
    full_done = 1'b0;
    wait_valid();
    accept();
    counts("t9", 1, 1);

    // Saturation: 257 wrong-label predictions against 8-bit counters
    rst_flag = 1'b1;
    @(negedge clk);
    rst_flag = 1'b0;
    for (int i = 0; i < 10; i++) sum_drv[i] = 32'(i);
    pred_ready = 1'b1;
    for (int n = 0; n < 257; n++) begin
      issue(4'd0, 4'd9, 32'd9, 1'b0);
      wait_idle();
      if (n == 254) counts("sat_255", 255, 0);
    end
    pred_ready = 1'b0;
    counts("sat_final", 255, 0);

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
